// File: rtl/op_lut_src_parser.sv
// Source-port header parser for the op_lut pipeline.
// One classification entry per packet is queued in a fallthrough FIFO.
module op_lut_src_parser #(
    parameter int DATA_WIDTH       = 64,
    parameter int CTRL_WIDTH       = DATA_WIDTH / 8,
    parameter int NUM_QUEUES       = 8,
    parameter int NUM_QUEUES_WIDTH = $clog2(NUM_QUEUES),
    parameter logic [CTRL_WIDTH-1:0] IO_QUEUE_STAGE_NUM = 'hFF,
    parameter int SRC_PORT_POS     = 16,
    parameter int BYTE_LEN_POS     = 0,
    parameter int PORT_MAP_MODE    = 0,
    parameter int FIFO_DEPTH_BITS  = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [DATA_WIDTH-1:0]       in_data,
    input  logic [CTRL_WIDTH-1:0]       in_ctrl,
    input  logic                        in_wr,
    input  logic                        rd_hdr_parser,
    output logic                        hdr_vld,
    output logic                        parser_nearly_full,
    output logic                        is_from_cpu,
    output logic [NUM_QUEUES-1:0]       to_cpu_output_port,
    output logic [NUM_QUEUES-1:0]       from_cpu_output_port,
    output logic [NUM_QUEUES_WIDTH-1:0] input_port_num,
    output logic [15:0]                 pkt_byte_len,
    output logic                        src_port_invalid,
    output logic                        hdr_missing,
    output logic                        fifo_overflow
);

    localparam int DEPTH = 2 ** FIFO_DEPTH_BITS;
    localparam int CW    = FIFO_DEPTH_BITS + 1;
    localparam logic [15:0]   NQ       = 16'(NUM_QUEUES);
    localparam logic [15:0]   HALF     = 16'(NUM_QUEUES / 2);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] NEAR_CNT = CW'(DEPTH - 1);

    typedef struct packed {
        logic                        is_from_cpu;
        logic [NUM_QUEUES-1:0]       to_cpu;
        logic [NUM_QUEUES-1:0]       from_cpu;
        logic [NUM_QUEUES_WIDTH-1:0] port;
        logic [15:0]                 len;
        logic                        invalid;
        logic                        missing;
    } entry_t;

    typedef enum logic {PARSE_HDRS, WAIT_EOP} state_t;

    state_t                     state_q, state_d;
    logic                       hdr_seen_q, hdr_seen_d;
    logic [FIFO_DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_DEPTH_BITS-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]              count_q, count_d;
    entry_t                     mem_q [DEPTH];

    logic [15:0]           src_port;
    logic [15:0]           partner;
    logic                  src_cpu;
    logic [NUM_QUEUES-1:0] partner_oh;
    entry_t                hdr_entry, wr_entry, head;
    logic                  is_hdr, is_data;
    logic                  wr_req, wr_ok, pop, full, overflow;
    logic                  unused_bits;

    assign unused_bits = ^{in_data, partner};

    always_comb begin
        src_port   = in_data[SRC_PORT_POS +: 16];
        partner    = '0;
        src_cpu    = 1'b0;
        partner_oh = '0;
        hdr_entry      = '0;
        hdr_entry.len  = in_data[BYTE_LEN_POS +: 16];
        hdr_entry.port = src_port[NUM_QUEUES_WIDTH-1:0];
        if (src_port >= NQ) begin
            hdr_entry.invalid = 1'b1;
        end else begin
            if (PORT_MAP_MODE == 0) begin
                src_cpu = src_port[0];
                partner = src_cpu ? src_port - 16'd1 : src_port + 16'd1;
            end else begin
                src_cpu = (src_port >= HALF);
                partner = src_cpu ? src_port - HALF : src_port + HALF;
            end
            partner_oh = NUM_QUEUES'(1'b1) << partner[NUM_QUEUES_WIDTH-1:0];
            hdr_entry.is_from_cpu = src_cpu;
            if (src_cpu) hdr_entry.from_cpu = partner_oh;
            else         hdr_entry.to_cpu   = partner_oh;
        end
    end

    assign is_hdr  = in_wr && (in_ctrl == IO_QUEUE_STAGE_NUM);
    assign is_data = in_wr && (in_ctrl == '0);

    always_comb begin
        state_d    = state_q;
        hdr_seen_d = hdr_seen_q;
        wr_req     = 1'b0;
        wr_entry   = hdr_entry;
        unique case (state_q)
            PARSE_HDRS: begin
                if (is_hdr && !hdr_seen_q) begin
                    wr_req     = 1'b1;
                    hdr_seen_d = 1'b1;
                end else if (is_data) begin
                    state_d = WAIT_EOP;
                    // Keep the FIFO one-entry-per-packet even without a header
                    if (!hdr_seen_q) begin
                        wr_req           = 1'b1;
                        wr_entry         = '0;
                        wr_entry.missing = 1'b1;
                        wr_entry.invalid = 1'b1;
                    end
                end
            end
            WAIT_EOP: begin
                if (in_wr && in_ctrl != '0) begin
                    state_d    = PARSE_HDRS;
                    hdr_seen_d = 1'b0;
                end
            end
        endcase
    end

    always_comb begin
        pop      = rd_hdr_parser && (count_q != '0);
        full     = (count_q == FULL_CNT);
        wr_ok    = wr_req && (!full || pop);
        overflow = wr_req && full && !pop;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)   rd_ptr_d = rd_ptr_q + 1'b1;
        if (wr_ok && !pop)      count_d = count_q + 1'b1;
        else if (!wr_ok && pop) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= PARSE_HDRS;
            hdr_seen_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            hdr_seen_q <= hdr_seen_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && wr_ok) mem_q[wr_ptr_q] <= wr_entry;
    end

    assign head = (count_q != '0) ? mem_q[rd_ptr_q] : '0;

    assign hdr_vld              = (count_q != '0);
    assign parser_nearly_full   = (count_q >= NEAR_CNT);
    assign fifo_overflow        = overflow;
    assign is_from_cpu          = head.is_from_cpu;
    assign to_cpu_output_port   = head.to_cpu;
    assign from_cpu_output_port = head.from_cpu;
    assign input_port_num       = head.port;
    assign pkt_byte_len         = head.len;
    assign src_port_invalid     = head.invalid;
    assign hdr_missing          = head.missing;

endmodule

// File: tb/tb_op_lut_src_parser.sv
// Randomized bench for op_lut_src_parser in both port-map modes
// against a packet-level queue model.
module tb_op_lut_src_parser;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [63:0] in_data = '0;
    logic [7:0]  in_ctrl = '0;
    logic        in_wr = 1'b0;
    logic        rd_hdr_parser = 1'b0;

    logic       vld0, nf0, cpu0, inv0, miss0, ovf0;
    logic [7:0] to0, from0;
    logic [2:0] pn0;
    logic [15:0] len0;
    logic       vld1, nf1, cpu1, inv1, miss1, ovf1;
    logic [7:0] to1, from1;
    logic [2:0] pn1;
    logic [15:0] len1;

    always #5 clk = ~clk;

    op_lut_src_parser #(.PORT_MAP_MODE(0)) u_m0 (
        .clk(clk), .reset(reset), .in_data(in_data), .in_ctrl(in_ctrl),
        .in_wr(in_wr), .rd_hdr_parser(rd_hdr_parser),
        .hdr_vld(vld0), .parser_nearly_full(nf0), .is_from_cpu(cpu0),
        .to_cpu_output_port(to0), .from_cpu_output_port(from0),
        .input_port_num(pn0), .pkt_byte_len(len0),
        .src_port_invalid(inv0), .hdr_missing(miss0), .fifo_overflow(ovf0)
    );

    op_lut_src_parser #(.PORT_MAP_MODE(1)) u_m1 (
        .clk(clk), .reset(reset), .in_data(in_data), .in_ctrl(in_ctrl),
        .in_wr(in_wr), .rd_hdr_parser(rd_hdr_parser),
        .hdr_vld(vld1), .parser_nearly_full(nf1), .is_from_cpu(cpu1),
        .to_cpu_output_port(to1), .from_cpu_output_port(from1),
        .input_port_num(pn1), .pkt_byte_len(len1),
        .src_port_invalid(inv1), .hdr_missing(miss1), .fifo_overflow(ovf1)
    );

    typedef struct packed {
        bit        cpu;
        bit [7:0]  to;
        bit [7:0]  from;
        bit [2:0]  pn;
        bit [15:0] len;
        bit        inv;
        bit        miss;
    } ent_t;

    ent_t q0[$];
    ent_t q1[$];
    bit   m_body = 0;
    bit   m_seen = 0;
    int   n_err = 0;
    int   n_chk = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic ent_t ref_ent(input int mode, input int p, input int len);
        ent_t e;
        int   partner;
        bit   cpu;
        e = '0;
        e.len = 16'(len);
        e.pn = 3'(p % 8);
        if (p >= 8) begin
            e.inv = 1'b1;
            return e;
        end
        if (mode == 0) begin
            cpu = (p % 2) == 1;
            partner = cpu ? p - 1 : p + 1;
        end else begin
            cpu = p >= 4;
            partner = cpu ? p - 4 : p + 4;
        end
        e.cpu = cpu;
        if (cpu) e.from = 8'(1 << partner);
        else     e.to   = 8'(1 << partner);
        return e;
    endfunction

    function automatic ent_t miss_ent();
        ent_t e;
        e = '0;
        e.inv = 1'b1;
        e.miss = 1'b1;
        return e;
    endfunction

    task automatic step(input bit wr, input logic [7:0] ctrl,
                        input logic [63:0] data, input bit rd, input bit rst);
        bit   w;
        bit   popped;
        bit   full;
        ent_t e0, e1, h0, h1;
        reset = rst;
        in_wr = wr;
        in_ctrl = ctrl;
        in_data = data;
        rd_hdr_parser = rd;
        @(negedge clk);
        w = 0;
        e0 = '0;
        e1 = '0;
        if (!m_body && wr && ctrl == 8'hFF && !m_seen) begin
            w = 1;
            e0 = ref_ent(0, int'(data[31:16]), int'(data[15:0]));
            e1 = ref_ent(1, int'(data[31:16]), int'(data[15:0]));
        end else if (!m_body && wr && ctrl == 8'h00 && !m_seen) begin
            w = 1;
            e0 = miss_ent();
            e1 = miss_ent();
        end
        h0 = (q0.size() > 0) ? q0[0] : '0;
        h1 = (q1.size() > 0) ? q1[0] : '0;
        popped = rd && q0.size() > 0;
        full = q0.size() == 4;
        check("head0", {cpu0, to0, from0, pn0, len0, inv0, miss0}, h0);
        check("head1", {cpu1, to1, from1, pn1, len1, inv1, miss1}, h1);
        check("vld0", vld0, q0.size() > 0);
        check("vld1", vld1, q1.size() > 0);
        check("nfull0", nf0, q0.size() >= 3);
        check("nfull1", nf1, q1.size() >= 3);
        check("ovf0", ovf0, w && full && !popped);
        check("ovf1", ovf1, w && full && !popped);
        if (rst) begin
            q0.delete();
            q1.delete();
            m_body = 0;
            m_seen = 0;
        end else begin
            if (popped) begin
                void'(q0.pop_front());
                void'(q1.pop_front());
            end
            if (w && (!full || popped)) begin
                q0.push_back(e0);
                q1.push_back(e1);
            end
            if (!m_body) begin
                if (wr && ctrl == 8'hFF) m_seen = 1;
                else if (wr && ctrl == 8'h00) m_body = 1;
            end else if (wr && ctrl != 8'h00) begin
                m_body = 0;
                m_seen = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] hdr_word(input int p, input int len);
        return {$urandom, 16'(p), 16'(len)};
    endfunction

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic send_pkt(input int p, input int len, input bit rd_hdr);
        step(1, 8'hFF, hdr_word(p, len), rd_hdr, 0);
        step(1, 8'h00, rnd64(), 0, 0);
        step(1, 8'h80, rnd64(), 0, 0);
    endtask

    task automatic drain();
        for (int i = 0; i < 6; i++) step(0, 8'h00, '0, 1, 0);
    endtask

    function automatic bit rnd_rd();
        return $urandom_range(0, 2) == 0;
    endfunction

    task automatic rand_pkt();
        int p;
        int len;
        int nd;
        logic [7:0] eop;
        p = $urandom_range(0, 11);
        len = $urandom_range(0, 65535);
        nd = $urandom_range(1, 3);
        eop = 8'h01;
        eop = eop << $urandom_range(0, 7);
        if ($urandom_range(0, 3) == 0) step(1, 8'h35, rnd64(), rnd_rd(), 0);
        if ($urandom_range(0, 7) != 0) begin
            step(1, 8'hFF, hdr_word(p, len), rnd_rd(), 0);
            if ($urandom_range(0, 5) == 0) step(1, 8'hFF, rnd64(), rnd_rd(), 0);
        end
        for (int i = 0; i < nd; i++) begin
            if ($urandom_range(0, 3) == 0) step(0, 8'h00, rnd64(), rnd_rd(), 0);
            step(1, 8'h00, rnd64(), rnd_rd(), 0);
        end
        step(1, eop, rnd64(), rnd_rd(), 0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        step(0, 8'h00, '0, 0, 1);
        step(0, 8'h00, '0, 0, 0);

        send_pkt(4, 60, 0);
        check("p1_vld", vld0, 1'b1);
        check("p1_to", to0, 8'h20);
        check("p1_from", from0, 8'h00);
        check("p1_len", len0, 16'd60);
        step(0, 8'h00, '0, 1, 0);
        check("p1_pop", vld0, 1'b0);

        send_pkt(6, 100, 0);
        send_pkt(1, 200, 0);
        check("p2_cpu", cpu1, 1'b1);
        check("p2_from", from1, 8'h04);
        step(0, 8'h00, '0, 1, 0);
        check("p2_to", to1, 8'h20);
        drain();

        send_pkt(9, 64, 0);
        check("p3_inv", inv0, 1'b1);
        check("p3_pn", pn0, 3'd1);
        check("p3_vec", {to0, from0}, 16'h0);
        drain();

        step(1, 8'h00, rnd64(), 0, 0);
        step(1, 8'h01, rnd64(), 0, 0);
        check("p4_miss", miss0, 1'b1);
        send_pkt(3, 77, 1);
        check("p4_len", len0, 16'd77);
        drain();

        for (int i = 0; i < 5; i++) send_pkt(i, 10 + i, 0);
        drain();
        for (int i = 0; i < 4; i++) send_pkt(i, 20 + i, 0);
        send_pkt(5, 25, 1);
        drain();

        step(1, 8'hFF, hdr_word(2, 33), 0, 0);
        step(1, 8'h00, rnd64(), 0, 0);
        step(0, 8'h00, '0, 0, 1);
        step(1, 8'h00, rnd64(), 0, 0);
        step(1, 8'h04, rnd64(), 0, 0);
        check("p6_miss", miss0, 1'b1);
        step(0, 8'h00, '0, 1, 0);
        send_pkt(7, 1500, 0);
        check("p6_cpu", cpu0, 1'b1);
        check("p6_from", from0, 8'h40);
        drain();

        for (int i = 0; i < 300; i++) rand_pkt();
        drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
